// File: rtl/gpu_bram_arbiter.sv
// gpu_bram_arbiter: round-robin two-reader / one-writer front end for a 1R1W BRAM with a zero-fill sequencer
module gpu_bram_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int SIZE       = 1024,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_req_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   output logic                  rd_gnt_a,
   output logic                  rd_valid_a,
   input  logic                  rd_req_b,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic                  rd_gnt_b,
   output logic                  rd_valid_b,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   input  logic                  clear_start,
   output logic                  clear_busy,
   output logic                  clear_done,
   output logic [ADDR_WIDTH-1:0] mem_dout_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] mem_din_addr,
   output logic [DATA_WIDTH-1:0] mem_din
);
   typedef enum logic {IDLE, CLEAR} state_t;
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(SIZE - 1);
   state_t                r_state, w_next;
   logic [ADDR_WIDTH:0]   r_cnt, w_cnt_inc;
   logic                  r_ptr_b, r_valid_a, r_valid_b, r_we, r_done;
   logic [ADDR_WIDTH-1:0] r_din_addr;
   logic [DATA_WIDTH-1:0] r_din;
   logic                  w_last, w_start;
   assign w_cnt_inc     = r_cnt + (ADDR_WIDTH+1)'(1);
   assign w_last        = r_cnt == LAST;
   assign w_start       = r_state == IDLE && clear_start;
   assign rd_gnt_a      = rd_req_a && (!rd_req_b || !r_ptr_b);
   assign rd_gnt_b      = rd_req_b && (!rd_req_a || r_ptr_b);
   assign mem_dout_addr = rd_gnt_a ? rd_addr_a : rd_gnt_b ? rd_addr_b : '0;
   assign rd_data       = mem_dout;
   assign rd_valid_a    = r_valid_a;
   assign rd_valid_b    = r_valid_b;
   assign we            = r_we;
   assign mem_din_addr  = r_din_addr;
   assign mem_din       = r_din;
   assign clear_done    = r_done;
   // read side: pointer moves to the losing side after every grant; valids trail grants by the BRAM latency
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_ptr_b   <= 1'b0;
         r_valid_a <= 1'b0;
         r_valid_b <= 1'b0;
      end else begin
         r_valid_a <= rd_gnt_a;
         r_valid_b <= rd_gnt_b;
         if (rd_gnt_a || rd_gnt_b) r_ptr_b <= rd_gnt_a;
      end
   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   // next state and write-side handshakes; a clear request beats a same-cycle CPU write
   always_comb begin
      w_next     = r_state;
      wr_ready   = 1'b0;
      clear_busy = 1'b0;
      if (r_state == IDLE) begin
         wr_ready = !clear_start;
         if (clear_start) w_next = CLEAR;
      end else begin
         clear_busy = 1'b1;
         if (w_last) w_next = IDLE;
      end
   end
   // write port: CPU writes in IDLE, one zero word per cycle while clearing
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_din_addr <= '0;
         r_din      <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= r_state == CLEAR && w_last;
         if (w_start) begin
            r_cnt      <= '0;
            r_we       <= 1'b1;
            r_din_addr <= '0;
            r_din      <= '0;
         end else if (r_state == CLEAR) begin
            r_cnt      <= w_cnt_inc;
            r_we       <= !w_last;
            r_din_addr <= w_cnt_inc[ADDR_WIDTH-1:0];
         end else begin
            r_we <= wr_req;
            if (wr_req) begin
               r_din_addr <= wr_addr;
               r_din      <= wr_data;
            end
         end
      end
endmodule
